maze_ctrl: RTL and testbench
============================

Name: maze_ctrl

Overview:
Sequencer for the maze generator. Loads a seed, pulses the generator reset, and waits for done under a watchdog. It then snapshots the size x size maze and streams it out one row per valid/ready beat. On timeout it advances the seed through an LFSR and retries, up to a bounded count.

Parameters:
size, 16, maze width and height in cells (bits per row, number of rows); 4..64
N, $clog2(size), row index width
TIMEOUT, 4096, max cycles in RUN waiting for gen_done
MAX_RETRY, 3, retries after first timeout before error
SEED_INIT, 16'hACE1, seed used at reset and whenever a seed would be zero

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous active-high reset
start  in  1  begin a generation; sampled only in IDLE
seed_load  in  1  load seed_in into seed register; honoured only in IDLE
seed_in  in  16  seed value for seed_load
gen_rst  out  1  reset to maze generator
gen_seed  out  16  seed to maze generator, equals seed register
gen_done  in  1  generator completion, level
gen_maze  in  size*size  generator maze, row y at bits [y*size +: size]
row_valid  out  1  row beat valid
row_ready  in  1  downstream accepts row
row_data  out  size  current row
row_idx  out  N  current row index
row_last  out  1  high with row_idx == size-1
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; cleared by next accepted start
retry_cnt  out  4  retries used in current/last run, saturates at 15

Behaviour:
- Reset values: state IDLE, seed = SEED_INIT, gen_rst=1, row_valid=0, row_data=0, row_idx=0, row_last=0, busy=0, timeout_err=0, retry_cnt=0, snapshot=0.
- gen_rst held 1 in IDLE (generator parked) and for exactly 2 cycles in GRST; 0 in RUN, CAPT, STREAM.
- seed_load in IDLE: seed <= (seed_in==0 ? SEED_INIT : seed_in). If seed_load and start occur in the same cycle, the load applies first and the run uses the new seed.
- FSM:
  - IDLE: start -> GRST; clear timeout_err, retry_cnt, wdog.
  - GRST: 2 cycles with gen_rst=1 -> RUN; wdog=0.
  - RUN: gen_done=1 -> CAPT. Else wdog increments; when wdog==TIMEOUT-1 and no gen_done, it is a timeout:
    - retry_cnt < MAX_RETRY: seed <= lfsr(seed), retry_cnt++, -> GRST.
    - otherwise: timeout_err <= 1, -> IDLE.
    - gen_done in the same cycle as the timeout counts as done, not timeout.
  - CAPT: 1 cycle; snapshot <= gen_maze; row_idx <= 0 -> STREAM.
  - STREAM: row_valid=1, row_data = snapshot row row_idx, row_last = (row_idx==size-1). On row_valid&row_ready: if row_last -> IDLE (row_valid=0 next cycle, row_idx=0); else row_idx++.
- gen_done is ignored outside RUN.
- Handshake: row_data, row_idx, and row_last are stable while row_valid=1 and row_ready=0. row_valid never drops without acceptance except on rst. Back-to-back beats are allowed (one row per cycle with row_ready held 1).
- Latency: start in cycle 0 -> gen_rst low from cycle 3. gen_done seen in cycle k -> first row_valid at k+2.
- start while busy: ignored. seed_load while busy: ignored.
- lfsr: 16-bit Galois, shift right, XOR 16'hB400 when LSB=1. A result of 0 is replaced by SEED_INIT.
- The snapshot is isolated from gen_maze after CAPT. The generator may change during STREAM without affecting row_data.
- rst mid-run (any state): immediate return to reset values. Seed returns to SEED_INIT.
- Register widths: wdog is $clog2(TIMEOUT)+1 bits and never wraps.

Test Plan:
- Nominal run: size=8, seed_load 16'h1234, start. Model drives gen_done at RUN cycle 100 with rows 8'h01..8'h80, row_ready=1.
  -> gen_seed=16'h1234 and gen_rst high exactly 2 cycles. Rows stream 0..7 in 8 consecutive cycles with row_last only on idx 7. busy falls after the last beat; timeout_err=0, retry_cnt=0.
- Backpressure: row_ready toggles 1,0,0,1,…
  -> row_data/row_idx are held during stalls. Each row appears exactly once and in order.
- Single timeout: TIMEOUT=16, seed 16'h0001, gen_done withheld in the first RUN and asserted in the second.
  -> retry_cnt=1, gen_seed=16'hB400 on retry, then normal streaming.
- Exhausted retries: TIMEOUT=16, MAX_RETRY=3, gen_done never asserted.
  -> exactly 4 GRST pulses, timeout_err=1, retry_cnt=3, back in IDLE. The next start clears timeout_err.
- Edge events:
  -> seed_load with 16'h0000 gives gen_seed=16'hACE1.
  -> start during STREAM is ignored.
  -> gen_done on the timeout cycle is treated as success.
  -> gen_maze changing after CAPT does not alter row_data.
- Async reset mid-STREAM at row 3 (asserted off-edge).
  -> All outputs return to reset values immediately without waiting for clk. gen_rst=1, seed=16'hACE1.

Source files
------------

// File: rtl/maze_ctrl.sv
// maze_ctrl : sequencer for the maze generator.
//   Loads a seed, pulses the generator reset for two cycles, then waits for
//   gen_done under a watchdog. On completion the size x size maze is captured
//   into a local snapshot and streamed out one row per valid/ready beat.
//   On a watchdog timeout the seed is advanced through a 16-bit Galois LFSR
//   and the generation is retried, up to MAX_RETRY times, before flagging
//   timeout_err.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a generation (IDLE only)
//   seed_load, seed_in  load the seed register (IDLE only; zero maps to SEED_INIT)
//   gen_rst, gen_seed   generator reset and seed
//   gen_done, gen_maze  generator completion level and maze (row y at [y*size +: size])
//   row_valid/ready     row stream handshake
//   row_data/idx/last   current row, its index, last-row flag
//   busy                high in any state other than IDLE
//   timeout_err         sticky, cleared by the next accepted start
//   retry_cnt           retries used in the current/last run, saturates at 15
module maze_ctrl #(
   parameter int          size      = 16,
   parameter int          N         = $clog2(size),
   parameter int          TIMEOUT   = 4096,
   parameter int          MAX_RETRY = 3,
   parameter logic [15:0] SEED_INIT = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   seed_load,
   input  logic [15:0]            seed_in,
   output logic                   gen_rst,
   output logic [15:0]            gen_seed,
   input  logic                   gen_done,
   input  logic [size*size-1:0]   gen_maze,
   output logic                   row_valid,
   input  logic                   row_ready,
   output logic [size-1:0]        row_data,
   output logic [N-1:0]           row_idx,
   output logic                   row_last,
   output logic                   busy,
   output logic                   timeout_err,
   output logic [3:0]             retry_cnt
);

   localparam int              WD_W     = $clog2(TIMEOUT) + 1;
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [N-1:0]    ROW_LAST = N'(size - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRST,
      S_RUN,
      S_CAPT,
      S_STREAM
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [15:0]           r_seed;
   logic [WD_W-1:0]       r_wdog;
   logic                  r_grst_cnt;   // 0 on first GRST cycle, 1 on second
   logic [3:0]            r_retry;
   logic                  r_timeout_err;
   logic [size*size-1:0]  r_snap;
   logic [N-1:0]          r_row_idx;

   logic                  w_timeout;
   logic                  w_can_retry;
   logic                  w_accept;
   logic                  w_last;
   logic [15:0]           w_lfsr_raw;
   logic [15:0]           w_lfsr;

   // gen_done on the final watchdog cycle wins over the timeout
   assign w_timeout   = (r_state == S_RUN) && !gen_done && (r_wdog == WD_LAST);
   assign w_can_retry = int'(r_retry) < MAX_RETRY;
   assign w_last      = (r_row_idx == ROW_LAST);
   assign w_accept    = (r_state == S_STREAM) && row_ready;
   assign w_lfsr_raw  = {1'b0, r_seed[15:1]} ^ (r_seed[0] ? 16'hB400 : 16'h0000);
   assign w_lfsr      = (w_lfsr_raw == '0) ? SEED_INIT : w_lfsr_raw;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_GRST;
         S_GRST:   if (r_grst_cnt) w_state_nxt = S_RUN;
         S_RUN: begin
            if (gen_done)       w_state_nxt = S_CAPT;
            else if (w_timeout) w_state_nxt = w_can_retry ? S_GRST : S_IDLE;
         end
         S_CAPT:   w_state_nxt = S_STREAM;
         S_STREAM: if (w_accept && w_last) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // output logic
   always_comb begin
      gen_rst   = (r_state == S_IDLE) || (r_state == S_GRST);
      row_valid = (r_state == S_STREAM);
      row_last  = (r_state == S_STREAM) && w_last;
      busy      = (r_state != S_IDLE);
      row_data  = '0;
      if (r_state == S_STREAM) row_data = r_snap[int'(r_row_idx)*size +: size];
   end

   assign gen_seed    = r_seed;
   assign row_idx     = r_row_idx;
   assign timeout_err = r_timeout_err;
   assign retry_cnt   = r_retry;

   // datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seed        <= SEED_INIT;
         r_wdog        <= '0;
         r_grst_cnt    <= 1'b0;
         r_retry       <= '0;
         r_timeout_err <= 1'b0;
         r_snap        <= '0;
         r_row_idx     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (seed_load) r_seed <= (seed_in == '0) ? SEED_INIT : seed_in;
               if (start) begin
                  r_timeout_err <= 1'b0;
                  r_retry       <= '0;
                  r_wdog        <= '0;
                  r_grst_cnt    <= 1'b0;
               end
            end
            S_GRST: begin
               r_grst_cnt <= ~r_grst_cnt;
               r_wdog     <= '0;
            end
            S_RUN: begin
               if (!gen_done) begin
                  if (w_timeout) begin
                     r_wdog     <= '0;
                     r_grst_cnt <= 1'b0;
                     if (w_can_retry) begin
                        r_seed <= w_lfsr;
                        if (r_retry != 4'hF) r_retry <= r_retry + 4'd1;
                     end else begin
                        r_timeout_err <= 1'b1;
                     end
                  end else begin
                     r_wdog <= r_wdog + 1'b1;
                  end
               end
            end
            S_CAPT: begin
               r_snap    <= gen_maze;
               r_row_idx <= '0;
            end
            S_STREAM: begin
               if (w_accept) r_row_idx <= w_last ? '0 : r_row_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_maze_ctrl.sv
`timescale 1ns/1ps
module tb_maze_ctrl;

   localparam int SZ = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // instance A: long watchdog, used for streaming and reset checks
   logic             a_start, a_seed_load, a_gen_done, a_row_ready;
   logic [15:0]      a_seed_in, a_gen_seed;
   logic [SZ*SZ-1:0] a_gen_maze;
   logic             a_gen_rst, a_row_valid, a_row_last, a_busy, a_terr;
   logic [SZ-1:0]    a_row_data;
   logic [2:0]       a_row_idx;
   logic [3:0]       a_retry;

   // instance B: TIMEOUT=16, used for watchdog and retry checks
   logic             b_start, b_seed_load, b_gen_done, b_row_ready;
   logic [15:0]      b_seed_in, b_gen_seed;
   logic [SZ*SZ-1:0] b_gen_maze;
   logic             b_gen_rst, b_row_valid, b_row_last, b_busy, b_terr;
   logic [SZ-1:0]    b_row_data;
   logic [2:0]       b_row_idx;
   logic [3:0]       b_retry;

   maze_ctrl #(.size(SZ), .TIMEOUT(4096), .MAX_RETRY(3), .SEED_INIT(16'hACE1)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .seed_load(a_seed_load), .seed_in(a_seed_in),
      .gen_rst(a_gen_rst), .gen_seed(a_gen_seed), .gen_done(a_gen_done), .gen_maze(a_gen_maze),
      .row_valid(a_row_valid), .row_ready(a_row_ready), .row_data(a_row_data),
      .row_idx(a_row_idx), .row_last(a_row_last), .busy(a_busy),
      .timeout_err(a_terr), .retry_cnt(a_retry)
   );

   maze_ctrl #(.size(SZ), .TIMEOUT(16), .MAX_RETRY(3), .SEED_INIT(16'hACE1)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .seed_load(b_seed_load), .seed_in(b_seed_in),
      .gen_rst(b_gen_rst), .gen_seed(b_gen_seed), .gen_done(b_gen_done), .gen_maze(b_gen_maze),
      .row_valid(b_row_valid), .row_ready(b_row_ready), .row_data(b_row_data),
      .row_idx(b_row_idx), .row_last(b_row_last), .busy(b_busy),
      .timeout_err(b_terr), .retry_cnt(b_retry)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [SZ*SZ-1:0] maze;
      int exp_idx, cyc, hi_cyc, pulses;
      logic prev;

      rst = 1'b1;
      a_start = 0; a_seed_load = 0; a_seed_in = '0; a_gen_done = 0; a_gen_maze = '0; a_row_ready = 0;
      b_start = 0; b_seed_load = 0; b_seed_in = '0; b_gen_done = 0; b_gen_maze = '0; b_row_ready = 0;
      tick(2);

      // reset values
      chk("rst_gen_rst",   a_gen_rst,   1);
      chk("rst_seed",      a_gen_seed,  16'hACE1);
      chk("rst_valid",     a_row_valid, 0);
      chk("rst_data",      a_row_data,  0);
      chk("rst_idx",       a_row_idx,   0);
      chk("rst_last",      a_row_last,  0);
      chk("rst_busy",      a_busy,      0);
      chk("rst_err",       a_terr,      0);
      chk("rst_retry",     a_retry,     0);
      chk("rst_b_gen_rst", b_gen_rst,   1);
      rst = 1'b0;
      tick;

      // nominal run, start during STREAM, gen_maze changing after capture
      a_seed_load = 1; a_seed_in = 16'h1234; a_start = 1;
      tick;
      a_seed_load = 0; a_start = 0;
      chk("nom_seed",  a_gen_seed, 16'h1234);
      chk("nom_grst1", a_gen_rst,  1);
      chk("nom_busy",  a_busy,     1);
      tick;
      chk("nom_grst2", a_gen_rst,  1);
      tick;
      chk("nom_run_grst_low", a_gen_rst, 0);
      tick(100);
      a_gen_done = 1; a_gen_maze = 64'h8040201008040201; a_row_ready = 1;
      tick;
      a_gen_done = 0;
      chk("nom_capt_valid", a_row_valid, 0);
      tick;
      a_gen_maze = '1;
      for (int i = 0; i < 8; i++) begin
         chk("nom_valid", a_row_valid, 1);
         chk("nom_idx",   a_row_idx,   i);
         chk("nom_data",  a_row_data,  64'h1 << i);
         chk("nom_last",  a_row_last,  (i == 7));
         a_start = (i == 3);
         tick;
      end
      a_start = 0;
      chk("nom_end_valid", a_row_valid, 0);
      chk("nom_end_busy",  a_busy,      0);
      chk("nom_end_idx",   a_row_idx,   0);
      chk("nom_end_err",   a_terr,      0);
      chk("nom_end_retry", a_retry,     0);

      // backpressure: row_ready 1,0,0,1 repeating
      maze = 64'h0123456789ABCDEF;
      a_row_ready = 0;
      a_start = 1;
      tick;
      a_start = 0;
      tick(2);
      a_gen_done = 1; a_gen_maze = maze;
      tick;
      a_gen_done = 0;
      tick;
      exp_idx = 0; cyc = 0;
      while (exp_idx < 8 && cyc < 40) begin
         chk("bp_valid", a_row_valid, 1);
         chk("bp_idx",   a_row_idx,   exp_idx);
         chk("bp_data",  a_row_data,  maze[exp_idx*8 +: 8]);
         a_row_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         if (a_row_ready) exp_idx++;
         cyc++;
         tick;
      end
      chk("bp_all_rows",  exp_idx,     8);
      chk("bp_cycles",    cyc,         16);
      chk("bp_end_valid", a_row_valid, 0);

      // zero seed maps to SEED_INIT
      a_row_ready = 1;
      a_seed_load = 1; a_seed_in = 16'h0000;
      tick;
      a_seed_load = 0;
      chk("seed_zero", a_gen_seed, 16'hACE1);

      // load with start applies first; load while busy ignored; async reset mid-STREAM
      a_seed_load = 1; a_seed_in = 16'h5555; a_start = 1;
      tick;
      a_start = 0; a_seed_in = 16'h9999;
      chk("load_first", a_gen_seed, 16'h5555);
      tick;
      a_seed_load = 0;
      chk("load_busy_ignored", a_gen_seed, 16'h5555);
      tick;
      a_gen_done = 1; a_gen_maze = maze;
      tick;
      a_gen_done = 0;
      tick(4);
      chk("ar_row3_idx",  a_row_idx,  3);
      chk("ar_row3_data", a_row_data, 8'h89);
      #2 rst = 1'b1;
      #1;
      chk("ar_gen_rst", a_gen_rst,   1);
      chk("ar_valid",   a_row_valid, 0);
      chk("ar_idx",     a_row_idx,   0);
      chk("ar_data",    a_row_data,  0);
      chk("ar_busy",    a_busy,      0);
      chk("ar_seed",    a_gen_seed,  16'hACE1);
      tick;
      rst = 1'b0;
      tick;

      // single timeout then success
      b_seed_load = 1; b_seed_in = 16'h0001; b_start = 1;
      tick;
      b_seed_load = 0; b_start = 0;
      chk("to_seed", b_gen_seed, 16'h0001);
      tick(2);
      tick(16);
      chk("to_retry_grst", b_gen_rst,  1);
      chk("to_retry_cnt",  b_retry,    1);
      chk("to_retry_seed", b_gen_seed, 16'hB400);
      tick(2);
      chk("to_retry_run", b_gen_rst, 0);
      b_gen_done = 1; b_gen_maze = maze; b_row_ready = 1;
      tick;
      b_gen_done = 0;
      tick;
      chk("to_row0", b_row_data, 8'hEF);
      tick(8);
      chk("to_end_busy",  b_busy,  0);
      chk("to_end_retry", b_retry, 1);
      chk("to_end_err",   b_terr,  0);

      // gen_done on the timeout cycle counts as success
      b_start = 1;
      tick;
      b_start = 0;
      tick(2);
      tick(15);
      b_gen_done = 1;
      tick;
      b_gen_done = 0;
      chk("dto_capt_grst", b_gen_rst, 0);
      chk("dto_retry",     b_retry,   0);
      chk("dto_busy",      b_busy,    1);
      tick;
      chk("dto_stream", b_row_valid, 1);
      tick(8);
      chk("dto_end", b_busy, 0);

      // exhausted retries
      b_start = 1;
      tick;
      b_start = 0;
      hi_cyc = 0; pulses = 0; prev = 1'b0; cyc = 0;
      while (b_busy && cyc < 200) begin
         if (b_gen_rst) begin
            hi_cyc++;
            if (!prev) pulses++;
         end
         prev = b_gen_rst;
         cyc++;
         tick;
      end
      chk("ex_finished",    b_busy,    0);
      chk("ex_cycles",      cyc,       72);
      chk("ex_pulses",      pulses,    4);
      chk("ex_grst_cycles", hi_cyc,    8);
      chk("ex_err",         b_terr,    1);
      chk("ex_retry",       b_retry,   3);
      chk("ex_idle_grst",   b_gen_rst, 1);
      b_start = 1;
      tick;
      b_start = 0;
      chk("ex_err_cleared",   b_terr,  0);
      chk("ex_retry_cleared", b_retry, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
